// File: rtl/keccak_absorb_loader.sv
// Purpose: XOR-absorbs padded message words into the 5x5x64 Keccak state and hands each full block to keccak_f.
// Latency: an accepted word shows on perm_state the next cycle; perm_valid rises the cycle after the block's last word.
// Backpressure: in_ready drops outside ABSORB; perm_valid holds until perm_ready; one word per cycle with no bubbles.
module keccak_absorb_loader #(
  parameter int IN_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [4:0][4:0][63:0]  perm_state,
  output logic                   perm_valid,
  input  logic                   perm_ready,
  input  logic [4:0][4:0][63:0]  ret_state,
  input  logic                   ret_valid,
  output logic                   done,
  output logic                   err
);

  localparam int CW = 8;  // wide enough for 1152/8 = 144 words per block

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABSORB,
    S_HANDOFF,
    S_WAIT_RET,
    S_DONE
  } fsm_t;

  fsm_t            fsm_q, fsm_d;
  logic [1599:0]   st;          // flattened state string, lane i at [64i +: 64]
  logic [1:0]      mode_q;
  logic [CW-1:0]   word_cnt;
  logic [CW-1:0]   rate_words;
  logic [10:0]     bit_base;
  logic            last_blk;
  logic            err_q;
  logic            word_acc;
  logic            blk_end;

  // Words per block for the mode latched at start.
  always_comb begin
    rate_words = CW'(1152 / IN_W);
    case (mode_q)
      2'd0:    rate_words = CW'(1152 / IN_W);
      2'd1:    rate_words = CW'(1088 / IN_W);
      2'd2:    rate_words = CW'(832 / IN_W);
      default: rate_words = CW'(576 / IN_W);
    endcase
  end

  assign bit_base   = 11'(word_cnt) * 11'(IN_W);
  assign word_acc   = (fsm_q == S_ABSORB) && in_valid;
  assign blk_end    = (word_cnt == rate_words - CW'(1));
  assign perm_state = st;
  assign err        = err_q;

  // State register for the control FSM.
  always_ff @(posedge clk) begin
    if (rst) fsm_q <= S_IDLE;
    else     fsm_q <= fsm_d;
  end

  // Next-state and handshake outputs; start overrides everything.
  always_comb begin
    fsm_d      = fsm_q;
    in_ready   = (fsm_q == S_ABSORB);
    perm_valid = (fsm_q == S_HANDOFF);
    done       = (fsm_q == S_DONE);
    if (start) begin
      fsm_d = S_ABSORB;
    end else begin
      case (fsm_q)
        S_ABSORB: begin
          if (in_valid) begin
            if (blk_end)      fsm_d = S_HANDOFF;
            else if (in_last) fsm_d = S_IDLE;
          end
        end
        S_HANDOFF:  if (perm_ready) fsm_d = S_WAIT_RET;
        S_WAIT_RET: if (ret_valid)  fsm_d = last_blk ? S_DONE : S_ABSORB;
        default:    fsm_d = fsm_q;
      endcase
    end
  end

  // Datapath: word XOR into the rate, permuted-state reload, counters and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= '0;
      mode_q   <= 2'd0;
      word_cnt <= '0;
      last_blk <= 1'b0;
      err_q    <= 1'b0;
    end else if (start) begin
      st       <= '0;
      mode_q   <= mode;
      word_cnt <= '0;
      last_blk <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (fsm_q)
        S_ABSORB: begin
          if (word_acc) begin
            st[bit_base +: IN_W] <= st[bit_base +: IN_W] ^ in_data;
            word_cnt             <= word_cnt + CW'(1);
            if (blk_end)      last_blk <= in_last;
            else if (in_last) err_q    <= 1'b1;
          end
        end
        S_WAIT_RET: begin
          if (ret_valid) begin
            st       <= ret_state;
            word_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_absorb_loader.sv
module tb_keccak_absorb_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, start, in_valid, in_last, perm_ready, ret_valid;
  logic [1:0]            mode;
  logic [63:0]           in_data;
  logic [4:0][4:0][63:0] ret_state;

  logic                  r64, pv64, dn64, er64;
  logic                  r32, pv32, dn32, er32;
  logic                  r8,  pv8,  dn8,  er8;
  logic [4:0][4:0][63:0] ps64, ps32, ps8;

  keccak_absorb_loader #(.IN_W(64)) u_d64 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(r64), .perm_state(ps64),
    .perm_valid(pv64), .perm_ready(perm_ready), .ret_state(ret_state),
    .ret_valid(ret_valid), .done(dn64), .err(er64));

  keccak_absorb_loader #(.IN_W(32)) u_d32 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in_data(in_data[31:0]),
    .in_valid(in_valid), .in_last(in_last), .in_ready(r32), .perm_state(ps32),
    .perm_valid(pv32), .perm_ready(perm_ready), .ret_state(ret_state),
    .ret_valid(ret_valid), .done(dn32), .err(er32));

  keccak_absorb_loader #(.IN_W(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in_data(in_data[7:0]),
    .in_valid(in_valid), .in_last(in_last), .in_ready(r8), .perm_state(ps8),
    .perm_valid(pv8), .perm_ready(perm_ready), .ret_state(ret_state),
    .ret_valid(ret_valid), .done(dn8), .err(er8));

  // Select which instance the current test observes.
  int                    sel;
  logic                  ready_s, pv_s, done_s, err_s;
  logic [4:0][4:0][63:0] ps_s;

  always_comb begin
    ready_s = r64; pv_s = pv64; done_s = dn64; err_s = er64; ps_s = ps64;
    case (sel)
      1: begin ready_s = r32; pv_s = pv32; done_s = dn32; err_s = er32; ps_s = ps32; end
      2: begin ready_s = r8;  pv_s = pv8;  done_s = dn8;  err_s = er8;  ps_s = ps8;  end
      default: ;
    endcase
  end

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [1599:0] model;
  logic [1599:0] exp_q[$];
  logic [1599:0] exp_st;

  function automatic int bad_lane(input logic [1599:0] a, input logic [1599:0] b);
    for (int i = 0; i < 25; i++)
      if (a[64*i +: 64] !== b[64*i +: 64]) return i;
    return 0;
  endfunction

  // Reference absorb: word k of width w XORed into bits [k*w +: w] of the string.
  task automatic absorb_model(input int k, input int w, input logic [63:0] d);
    logic [63:0]   m;
    logic [1599:0] t;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    t = {1536'd0, d & m};
    model = model ^ (t << (k * w));
  endtask

  task automatic send(input logic [63:0] d, input logic last);
    int cnt;
    in_data = d; in_valid = 1'b1; in_last = last;
    cnt = 0;
    while (!ready_s && cnt < 50) begin @(negedge clk); cnt++; end
    n_checks++;
    if (ready_s !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready_timeout in_ready=%b required 1", ready_s);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] m);
    mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model = '0;
  endtask

  task automatic pulse_perm_ready();
    perm_ready = 1'b1;
    @(negedge clk);
    perm_ready = 1'b0;
  endtask

  task automatic pulse_ret();
    ret_valid = 1'b1;
    @(negedge clk);
    ret_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      n_checks++;
      if (ps_s !== '0) begin n_fail++; $display("FAIL reset_state dut%0d lane %0d got %h required 0", s, bad_lane(ps_s, '0), ps_s[bad_lane(ps_s, '0)/5][bad_lane(ps_s, '0)%5]); end
      n_checks++;
      if ({ready_s, pv_s, done_s, err_s} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags dut%0d ready/pv/done/err=%b required 0000", s, {ready_s, pv_s, done_s, err_s}); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sha512_w64();
    sel = 0;
    pulse_start(2'd3);
    for (int k = 0; k < 9; k++) begin
      absorb_model(k, 64, 64'(k + 1));
      send(64'(k + 1), k == 8);
    end
    exp_q.push_back(model);
    n_checks++;
    if (pv_s !== 1'b1 || ready_s !== 1'b0) begin n_fail++; $display("FAIL w64_handoff perm_valid=%b in_ready=%b required 1 0", pv_s, ready_s); end
    exp_st = exp_q.pop_front();
    n_checks++;
    if (ps_s !== exp_st) begin n_fail++; $display("FAIL w64_block lane %0d got %h required %h", bad_lane(ps_s, exp_st), ps_s[bad_lane(ps_s, exp_st)/5][bad_lane(ps_s, exp_st)%5], exp_st[64*bad_lane(ps_s, exp_st) +: 64]); end
    n_checks++;
    if (ps_s[0][0] !== 64'h1 || ps_s[1][3] !== 64'h9 || ps_s[1][4] !== 64'h0) begin n_fail++; $display("FAIL w64_lanes A00=%h A13=%h A14=%h required 1 9 0", ps_s[0][0], ps_s[1][3], ps_s[1][4]); end
    pulse_perm_ready();
    n_checks++;
    if (pv_s !== 1'b0 || done_s !== 1'b0) begin n_fail++; $display("FAIL w64_wait perm_valid=%b done=%b required 0 0", pv_s, done_s); end
    ret_state = {25{64'hA5A5_A5A5_A5A5_A5A5}};
    exp_q.push_back(ret_state);
    pulse_ret();
    repeat (2) @(negedge clk);
    n_checks++;
    if (done_s !== 1'b1) begin n_fail++; $display("FAIL w64_done done=%b required 1", done_s); end
    exp_st = exp_q.pop_front();
    n_checks++;
    if (ps_s !== exp_st) begin n_fail++; $display("FAIL w64_final lane %0d got %h required %h", bad_lane(ps_s, exp_st), ps_s[bad_lane(ps_s, exp_st)/5][bad_lane(ps_s, exp_st)%5], exp_st[64*bad_lane(ps_s, exp_st) +: 64]); end
  endtask

  task automatic test_two_blocks_w32();
    logic [4:0][4:0][63:0] ret1;
    sel = 1;
    pulse_start(2'd1);
    for (int k = 0; k < 34; k++) begin
      absorb_model(k, 32, 64'(k));
      send(64'(k), 1'b0);
    end
    exp_q.push_back(model);
    exp_st = exp_q.pop_front();
    n_checks++;
    if (ps_s !== exp_st) begin n_fail++; $display("FAIL w32_block1 lane %0d got %h required %h", bad_lane(ps_s, exp_st), ps_s[bad_lane(ps_s, exp_st)/5][bad_lane(ps_s, exp_st)%5], exp_st[64*bad_lane(ps_s, exp_st) +: 64]); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (pv_s !== 1'b1 || ready_s !== 1'b0) begin n_fail++; $display("FAIL w32_stall cycle %0d perm_valid=%b in_ready=%b required 1 0", i, pv_s, ready_s); end
      @(negedge clk);
    end
    pulse_perm_ready();
    for (int i = 0; i < 25; i++) ret1[i/5][i%5] = {16'hC0DE, 16'(i), 32'h5A5A_0000 + 32'(i)};
    ret_state = ret1;
    pulse_ret();
    n_checks++;
    if (ps_s !== ret1 || ready_s !== 1'b1) begin n_fail++; $display("FAIL w32_reload lane %0d got %h required %h in_ready=%b", bad_lane(ps_s, ret1), ps_s[bad_lane(ps_s, ret1)/5][bad_lane(ps_s, ret1)%5], ret1[bad_lane(ps_s, ret1)/5][bad_lane(ps_s, ret1)%5], ready_s); end
    model = ret1;
    for (int k = 0; k < 34; k++) begin
      absorb_model(k, 32, 64'(k));
      send(64'(k), k == 33);
    end
    exp_q.push_back(model);
    n_checks++;
    if (pv_s !== 1'b1) begin n_fail++; $display("FAIL w32_handoff2 perm_valid=%b required 1", pv_s); end
    exp_st = exp_q.pop_front();
    n_checks++;
    if (ps_s !== exp_st) begin n_fail++; $display("FAIL w32_block2 lane %0d got %h required %h", bad_lane(ps_s, exp_st), ps_s[bad_lane(ps_s, exp_st)/5][bad_lane(ps_s, exp_st)%5], exp_st[64*bad_lane(ps_s, exp_st) +: 64]); end
    for (int i = 17; i < 25; i++) begin
      n_checks++;
      if (ps_s[i/5][i%5] !== ret1[i/5][i%5]) begin n_fail++; $display("FAIL w32_capacity lane %0d got %h required %h", i, ps_s[i/5][i%5], ret1[i/5][i%5]); end
    end
    pulse_perm_ready();
    ret_state = {25{64'h0123_4567_89AB_CDEF}};
    pulse_ret();
    n_checks++;
    if (done_s !== 1'b1 || ps_s !== {25{64'h0123_4567_89AB_CDEF}}) begin n_fail++; $display("FAIL w32_done done=%b lane0=%h required 1 0123456789abcdef", done_s, ps_s[0][0]); end
  endtask

  task automatic test_early_last();
    sel = 0;
    pulse_start(2'd0);
    for (int k = 0; k < 10; k++) begin
      absorb_model(k, 64, 64'(k + 100));
      send(64'(k + 100), k == 9);
    end
    n_checks++;
    if (err_s !== 1'b1 || ready_s !== 1'b0 || pv_s !== 1'b0) begin n_fail++; $display("FAIL early_last err=%b in_ready=%b perm_valid=%b required 1 0 0", err_s, ready_s, pv_s); end
    n_checks++;
    if (ps_s !== model) begin n_fail++; $display("FAIL early_state lane %0d got %h required %h", bad_lane(ps_s, model), ps_s[bad_lane(ps_s, model)/5][bad_lane(ps_s, model)%5], model[64*bad_lane(ps_s, model) +: 64]); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (pv_s !== 1'b0 || err_s !== 1'b1) begin n_fail++; $display("FAIL early_idle cycle %0d perm_valid=%b err=%b required 0 1", i, pv_s, err_s); end
    end
    pulse_start(2'd0);
    n_checks++;
    if (err_s !== 1'b0 || ready_s !== 1'b1) begin n_fail++; $display("FAIL early_restart err=%b in_ready=%b required 0 1", err_s, ready_s); end
  endtask

  task automatic test_start_in_wait();
    sel = 0;
    pulse_start(2'd3);
    for (int k = 0; k < 9; k++) send(64'hF0 + 64'(k), k == 8);
    pulse_perm_ready();
    n_checks++;
    if (ready_s !== 1'b0 || pv_s !== 1'b0) begin n_fail++; $display("FAIL wait_ret in_ready=%b perm_valid=%b required 0 0", ready_s, pv_s); end
    pulse_start(2'd3);
    n_checks++;
    if (ps_s !== '0 || ready_s !== 1'b1) begin n_fail++; $display("FAIL abort_clear lane0=%h in_ready=%b required 0 1", ps_s[0][0], ready_s); end
    ret_state = {25{64'hDEAD_BEEF_DEAD_BEEF}};
    pulse_ret();
    n_checks++;
    if (ps_s !== '0 || ready_s !== 1'b1 || done_s !== 1'b0) begin n_fail++; $display("FAIL stale_ret lane0=%h in_ready=%b done=%b required 0 1 0", ps_s[0][0], ready_s, done_s); end
  endtask

  task automatic test_bytes_w8();
    logic [7:0] b [104];
    sel = 2;
    pulse_start(2'd2);
    for (int k = 0; k < 104; k++) begin
      b[k] = 8'($urandom_range(0, 255));
      absorb_model(k, 8, {56'd0, b[k]});
      if (k == 103) begin
        n_checks++;
        if (pv_s !== 1'b0) begin n_fail++; $display("FAIL w8_early_handoff perm_valid=%b required 0", pv_s); end
      end
      send({56'd0, b[k]}, k == 103);
      if (k != 103) @(negedge clk);
    end
    exp_q.push_back(model);
    n_checks++;
    if (pv_s !== 1'b1) begin n_fail++; $display("FAIL w8_handoff perm_valid=%b required 1", pv_s); end
    exp_st = exp_q.pop_front();
    n_checks++;
    if (ps_s !== exp_st) begin n_fail++; $display("FAIL w8_block lane %0d got %h required %h", bad_lane(ps_s, exp_st), ps_s[bad_lane(ps_s, exp_st)/5][bad_lane(ps_s, exp_st)%5], exp_st[64*bad_lane(ps_s, exp_st) +: 64]); end
    for (int k = 0; k < 104; k++) begin
      int ln;
      ln = k / 8;
      n_checks++;
      if (ps_s[ln/5][ln%5][8*(k%8) +: 8] !== b[k]) begin n_fail++; $display("FAIL w8_byte %0d got %h required %h", k, ps_s[ln/5][ln%5][8*(k%8) +: 8], b[k]); end
    end
    for (int i = 13; i < 25; i++) begin
      n_checks++;
      if (ps_s[i/5][i%5] !== 64'h0) begin n_fail++; $display("FAIL w8_capacity lane %0d got %h required 0", i, ps_s[i/5][i%5]); end
    end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    pulse_start(2'd3);
    for (int k = 0; k < 3; k++) send(64'h77 + 64'(k), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (ps_s !== '0 || {ready_s, pv_s, done_s, err_s} !== 4'b0000) begin n_fail++; $display("FAIL reset_mid lane0=%h ready/pv/done/err=%b required 0 0000", ps_s[0][0], {ready_s, pv_s, done_s, err_s}); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 0; rst = 1'b1; start = 1'b0; mode = 2'd0; in_data = '0;
    in_valid = 1'b0; in_last = 1'b0; perm_ready = 1'b0; ret_valid = 1'b0;
    ret_state = '0; model = '0;
    @(negedge clk);
    test_reset();
    test_sha512_w64();
    test_two_blocks_w32();
    test_early_last();
    test_start_in_wait();
    test_bytes_w8();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
